// File: rtl/cond_sel_pkg.sv
// Shared constants and width helpers for the conditional selector pipeline.
package cond_sel_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_CHANNELS = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   // A single channel still needs a one-bit index port.
   function automatic int idx_width(input int channels);
      return (channels <= 1) ? 1 : clog2(channels);
   endfunction

endpackage

// File: rtl/cond_sel_if.sv
// Handshake and data bundle between a producer/consumer (master) and cond_sel_pipe (slave).
interface cond_sel_if
   import cond_sel_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) ();

   localparam int IDX_W = idx_width(CHANNELS);

   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] data_i;
   logic [CHANNELS*WIDTH-1:0] cond_i;
   logic [WIDTH-1:0]          default_i;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          y;
   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;

   modport master (
      output in_valid, data_i, cond_i, default_i, out_ready,
      input  in_ready, out_valid, y, hit, hit_idx
   );

   modport slave (
      input  in_valid, data_i, cond_i, default_i, out_ready,
      output in_ready, out_valid, y, hit, hit_idx
   );

endinterface

// File: rtl/cond_sel_prio.sv
// Combinational priority encoder and mux: lowest-index channel with a nonzero condition wins.
module cond_sel_prio
   import cond_sel_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   localparam int IDX_W   = idx_width(CHANNELS)
) (
   input  logic [CHANNELS*WIDTH-1:0] data_i,
   input  logic [CHANNELS*WIDTH-1:0] cond_i,
   input  logic [WIDTH-1:0]          fallback,
   output logic [WIDTH-1:0]          sel_y,
   output logic                      sel_hit,
   output logic [IDX_W-1:0]          sel_idx
);

   // Scan from the top down so the lowest qualifying index is the last to overwrite.
   always_comb begin
      sel_y   = fallback;
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (|cond_i[k*WIDTH +: WIDTH]) begin
            sel_y   = data_i[k*WIDTH +: WIDTH];
            sel_hit = 1'b1;
            sel_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/cond_sel_pipe.sv
// Registered N-way conditional selector behind a valid/ready handshake.
// Define COND_SEL_HOLD_EN to make a miss reuse the last accepted hit value instead of default_i.
module cond_sel_pipe
   import cond_sel_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) (
   input logic      clk,
   input logic      rst_n,
   cond_sel_if.slave bus
);

   localparam int IDX_W = idx_width(CHANNELS);

   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] fallback;
   logic [WIDTH-1:0] sel_y;
   logic             sel_hit;
   logic [IDX_W-1:0] sel_idx;

   logic             valid_q;
   logic [WIDTH-1:0] y_q;
   logic             hit_q;
   logic [IDX_W-1:0] idx_q;

   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

`ifdef COND_SEL_HOLD_EN
   logic [WIDTH-1:0] held_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= '0;
      end else if (accept && sel_hit) begin
         held_q <= sel_y;
      end
   end

   assign fallback = held_q;
`else
   assign fallback = bus.default_i;
`endif

   cond_sel_prio #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_prio (
      .data_i   (bus.data_i),
      .cond_i   (bus.cond_i),
      .fallback (fallback),
      .sel_y    (sel_y),
      .sel_hit  (sel_hit),
      .sel_idx  (sel_idx)
   );

   // A drain with a simultaneous accept keeps valid high; a bare drain clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q   <= '0;
         hit_q <= 1'b0;
         idx_q <= '0;
      end else if (accept) begin
         y_q   <= sel_y;
         hit_q <= sel_hit;
         idx_q <= sel_idx;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.y         = y_q;
   assign bus.hit       = hit_q;
   assign bus.hit_idx   = idx_q;

endmodule
